// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared op codes, FSM state and access-size helpers.
package mem_access_ctrl_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_BU = 3'b010;
  localparam logic [2:0] OP_H  = 3'b011;
  localparam logic [2:0] OP_HU = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic [1:0] {SZ_W, SZ_B, SZ_H} size_e;

  // Undefined op codes fall back to word accesses.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: op_size = SZ_B;
      OP_H, OP_HU: op_size = SZ_H;
      default:     op_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline request/response and data-memory bus signals.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_adel;
  logic        resp_ades;
  logic        resp_buserr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_buserr,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_buserr,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_lane_ext.sv
// rtl/mem_access_ctrl_load_lane_ext.sv - picks the load lane out of a bus word and extends it.
module load_lane_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o
);

  logic [31:0] byte_sh;
  logic [15:0] half;

  always_comb begin
    byte_sh = word_i >> {addr_lo_i, 3'b000};
    half    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    data_o  = word_i;
    case (op_size(op_i))
      SZ_B: data_o = (op_i == OP_B) ? {{24{byte_sh[7]}}, byte_sh[7:0]} : {24'b0, byte_sh[7:0]};
      SZ_H: data_o = (op_i == OP_H) ? {{16{half[15]}}, half} : {16'b0, half};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences MEM-stage loads/stores onto the multi-cycle data bus
// with alignment checks, lane steering, ack timeout and a ready/valid stall.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  io
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q;
  logic [2:0]       op_q;
  logic             we_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q, resp_valid_q, adel_q, ades_q, buserr_q;
  logic [31:0]      rdata_q;
  logic             bus_req_q, bus_we_q;
  logic [31:0]      bus_addr_q, bus_wdata_q;
  logic [3:0]       bus_be_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_d;
  logic        misal_d;
  size_e       sz_d;

  always_comb begin
    sz_d    = op_size(io.req_op);
    be_d    = 4'b1111;
    wdata_d = io.req_wdata;
    misal_d = 1'b0;
    case (sz_d)
      SZ_B: begin
        be_d    = 4'b0001 << io.req_addr[1:0];
        wdata_d = {4{io.req_wdata[7:0]}};
      end
      SZ_H: begin
        be_d    = io.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{io.req_wdata[15:0]}};
        misal_d = io.req_addr[0];
      end
      default: misal_d = (io.req_addr[1:0] != 2'b00);
    endcase
  end

  load_lane_ext u_ext (
    .word_i    (io.bus_rdata),
    .addr_lo_i (lo_q),
    .op_i      (op_q),
    .data_o    (ext_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_W;
      we_q         <= 1'b0;
      lo_q         <= 2'b00;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      buserr_q     <= 1'b0;
      rdata_q      <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.req_valid && ready_q) begin
            ready_q <= 1'b0;
            if (misal_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              adel_q       <= !io.req_we;
              ades_q       <= io.req_we;
            end else begin
              state_q     <= ST_BUSY;
              op_q        <= io.req_op;
              we_q        <= io.req_we;
              lo_q        <= io.req_addr[1:0];
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= io.req_we;
              bus_addr_q  <= {io.req_addr[31:2], 2'b00};
              bus_be_q    <= io.req_we ? be_d : 4'b1111;
              bus_wdata_q <= io.req_we ? wdata_d : 32'b0;
            end
          end
        end
        ST_BUSY: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (io.bus_ack || (TIMEOUT != 0 && cnt_q == TO_LAST)) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            buserr_q     <= !io.bus_ack;
            rdata_q      <= (io.bus_ack && !we_q) ? ext_d : 32'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          adel_q       <= 1'b0;
          ades_q       <= 1'b0;
          buserr_q     <= 1'b0;
          rdata_q      <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign io.req_ready   = ready_q;
  assign io.resp_valid  = resp_valid_q;
  assign io.resp_rdata  = rdata_q;
  assign io.resp_adel   = adel_q;
  assign io.resp_ades   = ades_q;
  assign io.resp_buserr = buserr_q;
  assign io.bus_req     = bus_req_q;
  assign io.bus_we      = bus_we_q;
  assign io.bus_addr    = bus_addr_q;
  assign io.bus_be      = bus_be_q;
  assign io.bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - vector table of loads/stores plus reset and timeout sequences.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic clk;
  logic reset;
  mem_access_ctrl_if io();

  mem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] exp_rd;
    logic [2:0]  err;
  } vec_t;

  vec_t vecs[15];
  int total = 0;
  int bad = 0;
  int cur = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d act=%h exp=%h", nm, cur, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    int nb;
    @(negedge clk);
    chk("ready_idle", io.req_ready, 1);
    io.req_valid = 1'b1;
    io.req_we    = v.we;
    io.req_op    = v.op;
    io.req_addr  = v.addr;
    io.req_wdata = v.wdata;
    @(posedge clk);
    #1;
    io.req_valid = 1'b0;
    io.req_we    = ~v.we;
    io.req_op    = 3'b101;
    io.req_addr  = ~v.addr;
    io.req_wdata = ~v.wdata;
    if (v.err[1:0] != 2'b00) begin
      @(negedge clk);
      chk("err_bus_req", io.bus_req, 0);
    end else begin
      nb = (v.ack_at >= 0) ? v.ack_at + 1 : TMO;
      for (int c = 0; c < nb; c++) begin
        @(negedge clk);
        chk("bus_req", io.bus_req, 1);
        chk("bus_addr", io.bus_addr, {v.addr[31:2], 2'b00});
        chk("bus_be", io.bus_be, v.be);
        chk("bus_we", io.bus_we, v.we);
        if (v.we) chk("bus_wdata", io.bus_wdata, v.bwdata);
        chk("busy_ready", io.req_ready, 0);
        chk("busy_resp_valid", io.resp_valid, 0);
        io.req_op = 3'($urandom_range(0, 7));
        io.req_addr = $urandom;
        if (c == v.ack_at) begin
          io.bus_ack   = 1'b1;
          io.bus_rdata = v.rdata;
        end
        @(posedge clk);
        #1;
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'h5A5A_A5A5;
      end
      @(negedge clk);
      chk("resp_bus_req", io.bus_req, 0);
    end
    chk("resp_valid", io.resp_valid, 1);
    chk("resp_ready", io.req_ready, 0);
    chk("resp_rdata", io.resp_rdata, v.exp_rd);
    chk("resp_adel", io.resp_adel, v.err[0]);
    chk("resp_ades", io.resp_ades, v.err[1]);
    chk("resp_buserr", io.resp_buserr, v.err[2]);
    @(negedge clk);
    chk("post_valid", io.resp_valid, 0);
    chk("post_ready", io.req_ready, 1);
    chk("post_err", {io.resp_adel, io.resp_ades, io.resp_buserr}, 0);
    chk("post_rdata", io.resp_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //          we    op      addr          wdata         rdata         ack be       bwdata        exp_rd        err
    vecs[0]  = '{1'b0, 3'b001, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'b1111, 32'h0,        32'hFFFF_FF80, 3'b000};
    vecs[1]  = '{1'b1, 3'b011, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1234_5678, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        3'b000};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0,        0, 4'b1111, 32'h0,        32'h0,        3'b001};
    vecs[3]  = '{1'b1, 3'b000, 32'h0000_0006, 32'h1111_2222, 32'h0,        0, 4'b1111, 32'h0,        32'h0,        3'b010};
    vecs[4]  = '{1'b0, 3'b000, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, -1, 4'b1111, 32'h0,       32'h0,        3'b100};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 3, 4'b1111, 32'h0,        32'hCAFE_F00D, 3'b000};
    vecs[6]  = '{1'b0, 3'b011, 32'h0000_3002, 32'h0,        32'h9ABC_0000, 3, 4'b1111, 32'h0,        32'hFFFF_9ABC, 3'b000};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_1001, 32'h0,        32'h0000_F300, 2, 4'b1111, 32'h0,        32'h0000_00F3, 3'b000};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_5001, 32'h0000_00A5, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        3'b000};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_5003, 32'h1122_3344, 32'h0,        0, 4'b1000, 32'h4444_4444, 32'h0,        3'b000};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_6000, 32'h0000_1234, 32'h0,        1, 4'b0011, 32'h1234_1234, 32'h0,        3'b000};
    vecs[11] = '{1'b0, 3'b111, 32'h0000_7000, 32'h0,        32'h8765_4321, 0, 4'b1111, 32'h0,        32'h8765_4321, 3'b000};
    vecs[12] = '{1'b0, 3'b100, 32'h0000_3000, 32'h0,        32'h1234_8001, 0, 4'b1111, 32'h0,        32'h0000_8001, 3'b000};
    vecs[13] = '{1'b1, 3'b000, 32'h0000_8000, 32'h0BAD_F00D, 32'h0,        2, 4'b1111, 32'h0BAD_F00D, 32'h0,        3'b000};
    vecs[14] = '{1'b1, 3'b011, 32'h0000_0003, 32'h0000_7777, 32'h0,        0, 4'b1111, 32'h0,        32'h0,        3'b010};

    reset        = 1'b1;
    io.req_valid = 1'b0;
    io.req_we    = 1'b0;
    io.req_op    = 3'b000;
    io.req_addr  = '0;
    io.req_wdata = '0;
    io.bus_ack   = 1'b0;
    io.bus_rdata = '0;
    #3;
    chk("rst_ready", io.req_ready, 1);
    chk("rst_bus_req", io.bus_req, 0);
    chk("rst_resp_valid", io.resp_valid, 0);
    chk("rst_outs", {io.resp_adel, io.resp_ades, io.resp_buserr, io.bus_we, io.bus_be}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cur = i;
      apply(vecs[i]);
    end

    // Reset in the middle of a bus transaction, then a stray ack.
    cur = 100;
    @(negedge clk);
    io.req_valid = 1'b1;
    io.req_we    = 1'b0;
    io.req_op    = 3'b000;
    io.req_addr  = 32'h0000_9000;
    @(posedge clk);
    #1 io.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_bus_req", io.bus_req, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_bus_req", io.bus_req, 0);
    chk("async_ready", io.req_ready, 1);
    chk("async_resp_valid", io.resp_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    io.bus_ack   = 1'b1;
    io.bus_rdata = 32'hDEAD_DEAD;
    @(posedge clk);
    #1 io.bus_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_ack_valid", io.resp_valid, 0);
      chk("stray_ack_ready", io.req_ready, 1);
    end

    cur = 101;
    apply(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every MEM-stage load/store onto the multi-cycle data-memory bus.
- Checks alignment, generates word address, byte enables and lane-shifted store data.
- Waits for bus acknowledge with a timeout, then returns lane-extracted, sign/zero-extended load data.
- Stalls the pipeline through a ready/valid handshake.

Parameters:
- TIMEOUT, 16, wait cycles without bus_ack before a bus error is reported; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage presents an access
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; stores use 000/001/011 (010→001, 100→011); 101-111 treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  controller idle; a request is accepted when req_valid && req_ready
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_adel  out  1  load address error, qualified by resp_valid
- resp_ades  out  1  store address error, qualified by resp_valid
- resp_buserr  out  1  timeout error, qualified by resp_valid
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write
- bus_addr  out  32  {req_addr[31:2], 2'b00}
- bus_be  out  4  byte enables; all 1s for loads
- bus_wdata  out  32  lane-shifted store data
- bus_ack  in  1  single-cycle completion from memory
- bus_rdata  in  32  read word; valid when bus_ack = 1

Behaviour:
- All outputs are registered. Reset (asynchronous) forces state IDLE, req_ready=1, and every other output to 0, immediately and regardless of state. A bus transaction in flight is abandoned; a later bus_ack is ignored in IDLE.
- States: IDLE, BUSY, RESP.
- IDLE, on accept:
  - Misaligned (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with resp_adel (load) or resp_ades (store) set. No bus activity.
  - Otherwise: latch op, we and addr[1:0]; drive bus_req=1 and the bus_* fields; req_ready=0; go to BUSY. bus_req rises on the edge after the accept.
- Store lane rules:
  - byte: be = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: be = 1111; wdata unchanged.
- BUSY:
  - bus_* held stable. The timeout counter starts at 0 and increments each cycle without ack.
  - On bus_ack: deassert bus_req on the same edge, capture the extracted load data, go to RESP.
  - If TIMEOUT≠0 and counter == TIMEOUT−1 with no ack: deassert bus_req, set resp_buserr, go to RESP.
  - If bus_ack and the timeout coincide, bus_ack wins and no error is reported.
- Load extraction from bus_rdata using latched addr[1:0]:
  - byte: lane addr[1:0], sign-extend for op 001, zero-extend for op 010.
  - half: lane addr[1], sign-extend for op 011, zero-extend for op 100.
  - word: unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_* hold the result.
  - Next edge: resp_* cleared, req_ready=1, state IDLE.
  - A new request cannot be accepted in the RESP cycle, so back-to-back accesses are spaced by at least one idle cycle.
- Latency:
  - Aligned access, ack in the first BUSY cycle: resp_valid 2 cycles after accept.
  - Error access: resp_valid 1 cycle after accept.
- req_* are sampled only at accept; changes while BUSY are ignored.

Decomposition:
- Shared package:
  - op-code constants OP_W, OP_B, OP_BU, OP_H, OP_HU;
  - state encoding for IDLE/BUSY/RESP.
- Sub-module load_lane_ext (combinational): inputs word, addr[1:0] and op; output 32-bit extended data. Instantiated once, in the BUSY capture path.

Test Plan:
- Load byte signed, addr 0x1003, bus_rdata 0x80FF_1234 with ack in the first BUSY cycle → bus_addr 0x1000, bus_be 1111; resp_rdata 0xFFFF_FF80 two cycles after accept; req_ready low during BUSY/RESP.
- Store half, addr 0x2002, wdata 0xDEAD_BEEF → bus_be 1100, bus_wdata 0xBEEF_BEEF, bus_we 1; resp_valid after ack, resp_rdata 0.
- Load half unsigned, addr 0x0001 → resp_valid next cycle with resp_adel=1; bus_req never asserted. Same for a store word at 0x0006 → resp_ades=1.
- TIMEOUT=4, load with no ack → bus_req high exactly 4 cycles; then resp_valid with resp_buserr=1. Variant: ack on the 4th cycle → no error.
- Reset asserted mid-BUSY → bus_req and req_ready go to 0 and 1 asynchronously, with no clock edge needed. A stray bus_ack afterwards produces no resp_valid.
- Load halfword signed, addr 0x3002, rdata 0x9ABC_0000, ack delayed 3 cycles → resp_rdata 0xFFFF_9ABC. bus_* stay stable throughout BUSY, even when req_* toggle.
